// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALU codes,
// FSM states, datapath select enums and the decoded instruction class.
package mips_pkg;

    // Primary opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (instruction bits [5:0])
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_OR    = 6'b100101;

    // ALU control codes, shared with the ALU
    localparam logic [3:0] ALU_ADDIU = 4'b0000;
    localparam logic [3:0] ALU_SW    = 4'b0001;
    localparam logic [3:0] ALU_ADDU  = 4'b0010;
    localparam logic [3:0] ALU_JAL   = 4'b0011;
    localparam logic [3:0] ALU_LW    = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_BNE   = 4'b0110;
    localparam logic [3:0] ALU_J     = 4'b0111;
    localparam logic [3:0] ALU_JR    = 4'b1000;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        RD_RT  = 2'b00,
        RD_RD  = 2'b01,
        RD_R31 = 2'b10
    } reg_dst_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_src_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_RS     = 2'b11
    } pc_src_e;

    typedef enum logic [3:0] {
        CLS_ADDIU = 4'd0,
        CLS_SW    = 4'd1,
        CLS_ADDU  = 4'd2,
        CLS_JAL   = 4'd3,
        CLS_LW    = 4'd4,
        CLS_OR    = 4'd5,
        CLS_BNE   = 4'd6,
        CLS_J     = 4'd7,
        CLS_JR    = 4'd8,
        CLS_NONE  = 4'd15
    } inst_class_e;

endpackage

// File: rtl/mips_inst_decode.sv
// Combinational instruction decoder: opcode/funct -> class, valid, ALU code.
module mips_inst_decode
    import mips_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output inst_class_e cls,
    output logic        valid,
    output logic [3:0]  alu_ctrl
);

    // Classify the instruction; anything not listed stays CLS_NONE / invalid
    always_comb begin
        cls = CLS_NONE;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls = CLS_ADDU;
                    FN_OR:   cls = CLS_OR;
                    FN_JR:   cls = CLS_JR;
                    default: cls = CLS_NONE;
                endcase
            end
            OP_ADDIU: cls = CLS_ADDIU;
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            OP_BNE:   cls = CLS_BNE;
            OP_J:     cls = CLS_J;
            OP_JAL:   cls = CLS_JAL;
            default:  cls = CLS_NONE;
        endcase
    end

    // Map the class onto its ALU operation code
    always_comb begin
        valid    = 1'b1;
        alu_ctrl = ALU_ADDIU;
        case (cls)
            CLS_ADDIU: alu_ctrl = ALU_ADDIU;
            CLS_SW:    alu_ctrl = ALU_SW;
            CLS_ADDU:  alu_ctrl = ALU_ADDU;
            CLS_JAL:   alu_ctrl = ALU_JAL;
            CLS_LW:    alu_ctrl = ALU_LW;
            CLS_OR:    alu_ctrl = ALU_OR;
            CLS_BNE:   alu_ctrl = ALU_BNE;
            CLS_J:     alu_ctrl = ALU_J;
            CLS_JR:    alu_ctrl = ALU_JR;
            default:   valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle main control FSM for the MIPS core. Sequences fetch, decode,
// execute, memory and write-back, drives all datapath selects/enables and
// counts retired instructions.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RST    | one idle cycle after reset, all outputs low
// FETCH  | instruction read from PC; IR and PC load on mem_ready
// DECODE | opcode/funct sampled into the class register
// EXEC   | ALU op; branches and jumps update PC and finish here
// MEM    | data access at ALU result; sw finishes here on mem_ready
// WB     | register-file write for ALU ops and lw
// TRAP   | unsupported encoding; terminal until reset
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src_b,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_src,
    output logic        reg_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        illegal,
    output logic [31:0] retired
);

    state_e      state_q, state_d;
    inst_class_e cls_q, cls_d;
    logic [3:0]  alu_q, alu_d;
    logic [31:0] retired_q, retired_d;
    logic        retire;

    inst_class_e dec_cls;
    logic        dec_valid;
    logic [3:0]  dec_alu;

    mips_inst_decode u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .cls      (dec_cls),
        .valid    (dec_valid),
        .alu_ctrl (dec_alu)
    );

    // State, latched instruction class and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RST;
            cls_q     <= CLS_NONE;
            alu_q     <= ALU_ADDIU;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            alu_q     <= alu_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and output decode from registered state plus latched class
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        alu_d     = alu_q;
        retired_d = retired_q;
        retire    = 1'b0;

        alu_ctrl  = 4'b0000;
        alu_src_b = 1'b0;
        reg_dst   = RD_RT;
        wb_src    = WB_ALU;
        reg_write = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_PLUS4;
        illegal   = 1'b0;

        case (state_q)
            ST_RST: state_d = ST_FETCH;

            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end

            ST_DECODE: begin
                cls_d   = dec_cls;
                alu_d   = dec_alu;
                state_d = dec_valid ? ST_EXEC : ST_TRAP;
            end

            ST_EXEC: begin
                alu_ctrl  = alu_q;
                alu_src_b = (cls_q == CLS_ADDIU) || (cls_q == CLS_LW) || (cls_q == CLS_SW);
                case (cls_q)
                    CLS_ADDU, CLS_OR, CLS_ADDIU: state_d = ST_WB;
                    CLS_LW, CLS_SW:              state_d = ST_MEM;
                    CLS_BNE: begin
                        pc_write = ~zero;
                        pc_src   = PC_BRANCH;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CLS_J: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CLS_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = PC_JUMP;
                        reg_write = 1'b1;
                        reg_dst   = RD_R31;
                        wb_src    = WB_PC4;
                        retire    = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    CLS_JR: begin
                        pc_write = 1'b1;
                        pc_src   = PC_RS;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end

            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (cls_q == CLS_SW);
                if (mem_ready) begin
                    if (cls_q == CLS_SW) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end

            ST_WB: begin
                reg_write = 1'b1;
                reg_dst   = ((cls_q == CLS_ADDU) || (cls_q == CLS_OR)) ? RD_RD : RD_RT;
                wb_src    = (cls_q == CLS_LW) ? WB_MEM : WB_ALU;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end

            ST_TRAP: illegal = 1'b1;

            default: state_d = ST_RST;
        endcase

        if (retire) begin
            retired_d = retired_q + 32'd1;
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: each instruction is expanded into its expected
// cycle-by-cycle timeline (phase rules, stalls, retire point), driven
// into the controller and compared every cycle.
module tb_mips_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  alu_ctrl;
    logic        alu_src_b;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_src;
    logic        reg_write;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        illegal;
    logic [31:0] retired;

    mips_multicycle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .alu_ctrl  (alu_ctrl),
        .alu_src_b (alu_src_b),
        .reg_dst   (reg_dst),
        .wb_src    (wb_src),
        .reg_write (reg_write),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .iord      (iord),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .illegal   (illegal),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] alu;
        logic       srcb;
        logic [1:0] rdst;
        logic [1:0] wbs;
        logic       rw;
        logic       mreq;
        logic       mwe;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic [1:0] psrc;
        logic       ill;
    } outv_t;

    typedef struct {
        logic       rdy;
        logic       zro;
        logic [5:0] op;
        logic [5:0] fn;
        logic       last;
        outv_t      e;
    } cyc_t;

    // Instruction kinds used by the bench
    localparam int K_ADDIU = 0, K_SW = 1, K_ADDU = 2, K_JAL = 3, K_LW = 4;
    localparam int K_OR = 5, K_BNE = 6, K_J = 7, K_JR = 8;

    cyc_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc_no = 0;
    logic [31:0] exp_retired = 0;
    outv_t       last_seen;

    function automatic outv_t sample();
        outv_t o;
        o.alu  = alu_ctrl;
        o.srcb = alu_src_b;
        o.rdst = reg_dst;
        o.wbs  = wb_src;
        o.rw   = reg_write;
        o.mreq = mem_req;
        o.mwe  = mem_we;
        o.iord = iord;
        o.irw  = ir_write;
        o.pcw  = pc_write;
        o.psrc = pc_src;
        o.ill  = illegal;
        return o;
    endfunction

    task automatic check_vec(input string name, input outv_t act, input outv_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): dut=%h expected=%h", name, cyc_no, act, exp);
        end
    endtask

    task automatic check_int(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): dut=%0d expected=%0d", name, cyc_no, act, exp);
        end
    endtask

    // Instruction encodings and ALU codes as listed for the control unit
    task automatic get_enc(input int k, output logic [5:0] op, output logic [5:0] fn,
                           output logic [3:0] alu);
        fn = 6'($urandom_range(0, 63));
        case (k)
            K_ADDIU: begin op = 6'b001001; alu = 4'b0000; end
            K_SW:    begin op = 6'b101011; alu = 4'b0001; end
            K_ADDU:  begin op = 6'b000000; fn = 6'b100001; alu = 4'b0010; end
            K_JAL:   begin op = 6'b000011; alu = 4'b0011; end
            K_LW:    begin op = 6'b100011; alu = 4'b0100; end
            K_OR:    begin op = 6'b000000; fn = 6'b100101; alu = 4'b0101; end
            K_BNE:   begin op = 6'b000101; alu = 4'b0110; end
            K_J:     begin op = 6'b000010; alu = 4'b0111; end
            default: begin op = 6'b000000; fn = 6'b001000; alu = 4'b1000; end
        endcase
    endtask

    // A cycle with random don't-care inputs and all outputs expected low
    function automatic cyc_t idle();
        cyc_t c;
        c.rdy  = 1'($urandom_range(0, 1));
        c.zro  = 1'($urandom_range(0, 1));
        c.op   = 6'($urandom_range(0, 63));
        c.fn   = 6'($urandom_range(0, 63));
        c.last = 1'b0;
        c.e    = '0;
        return c;
    endfunction

    task automatic add_fetch(input int fst);
        cyc_t c;
        for (int i = 0; i <= fst; i++) begin
            c        = idle();
            c.rdy    = (i == fst);
            c.e.mreq = 1'b1;
            c.e.irw  = (i == fst);
            c.e.pcw  = (i == fst);
            q.push_back(c);
        end
    endtask

    // Expected timeline of one legal instruction
    task automatic build(input int k, input int fst, input int mst, input logic z);
        cyc_t       c;
        logic [5:0] op, fn;
        logic [3:0] alu;
        get_enc(k, op, fn, alu);
        add_fetch(fst);
        c    = idle();
        c.op = op;
        c.fn = fn;
        q.push_back(c);
        c        = idle();
        c.e.alu  = alu;
        c.e.srcb = (k == K_ADDIU || k == K_LW || k == K_SW);
        if (k == K_BNE) begin
            c.zro    = z;
            c.e.pcw  = ~z;
            c.e.psrc = 2'b01;
            c.last   = 1'b1;
        end else if (k == K_J) begin
            c.e.pcw  = 1'b1;
            c.e.psrc = 2'b10;
            c.last   = 1'b1;
        end else if (k == K_JAL) begin
            c.e.pcw  = 1'b1;
            c.e.psrc = 2'b10;
            c.e.rw   = 1'b1;
            c.e.rdst = 2'b10;
            c.e.wbs  = 2'b10;
            c.last   = 1'b1;
        end else if (k == K_JR) begin
            c.e.pcw  = 1'b1;
            c.e.psrc = 2'b11;
            c.last   = 1'b1;
        end
        q.push_back(c);
        if (k == K_SW || k == K_LW) begin
            for (int i = 0; i <= mst; i++) begin
                c        = idle();
                c.rdy    = (i == mst);
                c.e.mreq = 1'b1;
                c.e.iord = 1'b1;
                c.e.mwe  = (k == K_SW);
                c.last   = (k == K_SW) && (i == mst);
                q.push_back(c);
            end
        end
        if (k == K_ADDIU || k == K_ADDU || k == K_OR || k == K_LW) begin
            c        = idle();
            c.e.rw   = 1'b1;
            c.e.rdst = (k == K_ADDU || k == K_OR) ? 2'b01 : 2'b00;
            c.e.wbs  = (k == K_LW) ? 2'b01 : 2'b00;
            c.last   = 1'b1;
            q.push_back(c);
        end
    endtask

    // Unsupported encoding: fetch, decode, then a terminal trap
    task automatic build_trap(input logic [5:0] op, input logic [5:0] fn, input int n);
        cyc_t c;
        add_fetch(int'($urandom_range(0, 2)));
        c    = idle();
        c.op = op;
        c.fn = fn;
        q.push_back(c);
        for (int i = 0; i < n; i++) begin
            c       = idle();
            c.e.ill = 1'b1;
            q.push_back(c);
        end
    endtask

    // Drive and check up to n queued cycles (n < 0: all); entered just after a rising edge
    task automatic run(input int n);
        cyc_t c;
        int   cnt = 0;
        while (q.size() > 0 && (n < 0 || cnt < n)) begin
            c         = q.pop_front();
            mem_ready = c.rdy;
            zero      = c.zro;
            opcode    = c.op;
            funct     = c.fn;
            @(negedge clk);
            last_seen = sample();
            check_vec("outputs", last_seen, c.e);
            check_int("retired", retired, exp_retired);
            @(posedge clk);
            #1;
            cyc_no++;
            if (c.last) exp_retired = exp_retired + 32'd1;
            cnt++;
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        exp_retired = 0;
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_vec("rst_outputs", sample(), '0);
        check_int("rst_retired", retired, 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_stall();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
    endfunction

    initial begin
        outv_t hold_exp;
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = '0;
        funct     = '0;
        do_reset();

        // addu: 4 cycles, ALU code 0010 in EXEC, retired becomes 1
        build(K_ADDU, 0, 0, 1'b0);
        check_int("addu_len", q.size(), 32'd4);
        run(3);
        check_int("addu_alu", {28'd0, last_seen.alu}, 32'd2);
        run(-1);
        check_int("addu_retired", retired, 32'd1);

        // lw with three stalled MEM cycles: 8 cycles total, wb_src 01
        build(K_LW, 0, 3, 1'b0);
        check_int("lw_len", q.size(), 32'd8);
        run(-1);
        check_int("lw_wb_src", {30'd0, last_seen.wbs}, 32'd1);
        check_int("lw_retired", retired, 32'd2);

        // bne taken / not taken: 3 cycles each
        build(K_BNE, 0, 0, 1'b0);
        check_int("bne_len", q.size(), 32'd3);
        run(-1);
        check_int("bne_nz_pcw", {31'd0, last_seen.pcw}, 32'd1);
        build(K_BNE, 0, 0, 1'b1);
        run(-1);
        check_int("bne_z_pcw", {31'd0, last_seen.pcw}, 32'd0);

        // jal: PC and register writes in the same EXEC cycle
        build(K_JAL, 0, 0, 1'b0);
        run(-1);
        check_int("jal_exec", {18'd0, last_seen.pcw, last_seen.rw, last_seen.psrc,
                               last_seen.rdst, last_seen.wbs}, 32'b11101010);
        check_int("jal_retired", retired, 32'd5);

        // Randomized instruction stream with random stalls
        for (int i = 0; i < 150; i++) begin
            build(int'($urandom_range(0, 8)), rand_stall(), rand_stall(),
                  1'($urandom_range(0, 1)));
            run(-1);
        end

        // Traps: sticky illegal, no requests, retired frozen; reset clears
        build_trap(6'b111111, 6'($urandom_range(0, 63)), 20);
        run(-1);
        do_reset();
        build(K_OR, 1, 0, 1'b0);
        run(-1);
        build_trap(6'b000000, 6'b000000, 8);
        run(-1);
        do_reset();

        for (int i = 0; i < 40; i++) begin
            build(int'($urandom_range(0, 8)), rand_stall(), rand_stall(),
                  1'($urandom_range(0, 1)));
            run(-1);
        end

        // Reset during a stalled sw MEM cycle drops the request without a clock edge
        build(K_SW, 0, 5, 1'b0);
        run(4);
        mem_ready = 1'b0;
        #1;
        hold_exp      = '0;
        hold_exp.mreq = 1'b1;
        hold_exp.mwe  = 1'b1;
        hold_exp.iord = 1'b1;
        check_vec("sw_held", sample(), hold_exp);
        reset = 1'b1;
        #1;
        check_vec("async_reset", sample(), '0);
        check_int("async_retired", retired, 32'd0);
        do_reset();
        build(K_ADDIU, 0, 0, 1'b0);
        run(-1);
        check_int("post_reset_retired", retired, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
